// File: rtl/seq_normalizer.sv
// seq_normalizer
//
// Sequential left-normalizer for one 32-bit operand at a time. In logical
// mode the operand is shifted left until bit 31 is set. In arithmetic mode it
// is shifted left until bits 31 and 30 differ, capped at 31 shifts. The
// result, the shift count and a zero flag are then held until they are
// consumed.
//
// Build option:
//   SEQ_NORMALIZER_FAST_EN  when defined, a SHIFT cycle moves the operand by 4
//                           whenever doing so cannot skip past the stop point.
//                           Results are bit-identical; only latency shrinks.
//
// Ports:
//   clk         rising-edge clock for all state
//   rst         asynchronous, active-high reset
//   inValid     dataIn/arithmetic valid
//   inReady     block can accept an operand (IDLE and not in reset)
//   dataIn      operand to normalize
//   arithmetic  0 = logical (unsigned), 1 = arithmetic (signed) normalize
//   outValid    result valid (DONE)
//   outReady    consumer accepts result
//   dataOut     normalized value
//   shiftCount  left-shift amount applied, 0..32
//   isZero      operand was zero
//
// state | meaning
// IDLE  | waiting for an operand; inReady high
// SHIFT | one normalize step per cycle on the working register
// DONE  | result presented on outputs; waiting for outReady

module seq_normalizer (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] dataIn,
    input  logic        arithmetic,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] dataOut,
    output logic [5:0]  shiftCount,
    output logic        isZero
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0] work_q;
    logic [5:0]  cnt_q;
    logic        arith_q;
    logic        zero_q;

    logic        step_done;
    logic        work_is_zero;
`ifdef SEQ_NORMALIZER_FAST_EN
    logic        shift4;
`endif

    assign work_is_zero = (work_q == 32'd0);

    // Stop condition for the current SHIFT cycle.
    always_comb begin
        step_done = 1'b0;
        if (!arith_q) begin
            step_done = work_q[31] || work_is_zero;
        end else begin
            step_done = (work_q[31] != work_q[30]) || (cnt_q == 6'd31);
        end
    end

`ifdef SEQ_NORMALIZER_FAST_EN
    // A 4-bit step is only taken when all four shifted-out positions are
    // guaranteed to lie before the stop point, so it never overshoots.
    always_comb begin
        shift4 = 1'b0;
        if (!arith_q) begin
            shift4 = (work_q[31:28] == 4'd0) && !work_is_zero;
        end else begin
            shift4 = ((&work_q[31:27]) || (~|work_q[31:27])) && (cnt_q <= 6'd27);
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (inValid) state_d = ST_SHIFT;
            ST_SHIFT: if (step_done) state_d = ST_DONE;
            ST_DONE:  if (outReady) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic; inReady drops immediately with rst.
    always_comb begin
        inReady  = (state_q == ST_IDLE) && !rst;
        outValid = (state_q == ST_DONE);
    end

    // Working datapath and result registers. Results are only loaded on the
    // SHIFT->DONE transition so the outputs keep their last values otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q     <= 32'd0;
            cnt_q      <= 6'd0;
            arith_q    <= 1'b0;
            zero_q     <= 1'b0;
            dataOut    <= 32'd0;
            shiftCount <= 6'd0;
            isZero     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (inValid) begin
                        work_q  <= dataIn;
                        arith_q <= arithmetic;
                        cnt_q   <= 6'd0;
                        zero_q  <= (dataIn == 32'd0);
                    end
                end
                ST_SHIFT: begin
                    if (step_done) begin
                        dataOut    <= work_q;
                        // A zero operand in logical mode reports a full-width
                        // shift without iterating.
                        shiftCount <= (!arith_q && work_is_zero) ? 6'd32 : cnt_q;
                        isZero     <= zero_q;
                    end else begin
`ifdef SEQ_NORMALIZER_FAST_EN
                        if (shift4) begin
                            work_q <= {work_q[27:0], 4'b0000};
                            cnt_q  <= cnt_q + 6'd4;
                        end else begin
                            work_q <= {work_q[30:0], 1'b0};
                            cnt_q  <= cnt_q + 6'd1;
                        end
`else
                        work_q <= {work_q[30:0], 1'b0};
                        cnt_q  <= cnt_q + 6'd1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
